key_dir_arbiter: RTL and testbench

Producer of the 4-bit `btnstate` direction code consumed by the player-movement logic. Samples four raw direction-key levels from the keyboard front end, debounces each key, and resolves opposing keys per axis (last-pressed wins) so the emitted code is never 2'b11 on an axis. Also reports how long the current direction code has been held, for movement acceleration. Runs entirely on `clk22`, one update per game tick.

---
 rtl/key_dir_arbiter.sv | 132 +++++++++++++
 tb/tb_key_dir_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_dir_arbiter.sv
// key_dir_arbiter: debounces four direction keys, resolves opposing keys per
// axis with last-pressed-wins, and reports how long the current direction
// code has been held. Everything runs on clk22, one update per game tick.
module key_dir_arbiter #(
   parameter int DEBOUNCE = 2
) (
   input  logic       clk22,
   input  logic       rst,
   input  logic       gameover,
   input  logic [3:0] keys,
   output logic [3:0] btnstate,
   output logic [7:0] held
);

   // Axis state encoding doubles as the output code for that axis.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_A    = 2'b10;
   localparam logic [1:0] ST_B    = 2'b01;

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

   logic [3:0] filt;
   logic [3:0] filt_d_reg;
   logic [3:0] rise;
   logic [3:0] btn_next;
   logic [3:0] btn_reg;
   logic [7:0] held_reg;

   // Per-key debounce: the filtered level flips only after DEBOUNCE
   // consecutive disagreeing samples, so shorter glitches never pass.
   for (genvar gi = 0; gi < 4; gi++) begin : g_key
      logic [3:0] cnt_reg;
      logic       filt_reg;

      // Count consecutive disagreements and flip once the run is long enough.
      always_ff @(posedge clk22) begin
         if (rst) begin
            cnt_reg  <= 4'd0;
            filt_reg <= 1'b0;
         end else if (keys[gi] == filt_reg) begin
            cnt_reg  <= 4'd0;
         end else if (cnt_reg == DB_LAST) begin
            filt_reg <= keys[gi];
            cnt_reg  <= 4'd0;
         end else begin
            cnt_reg  <= cnt_reg + 4'd1;
         end
      end

      assign filt[gi] = filt_reg;
   end

   // Delayed copy of the filtered levels for rising-edge detection.
   always_ff @(posedge clk22) begin
      if (rst) filt_d_reg <= 4'b0000;
      else     filt_d_reg <= filt;
   end

   assign rise = filt & ~filt_d_reg;

   // Axis 0 is horizontal (a = left, b = right), axis 1 is vertical
   // (a = up, b = down); key bit 2*gi+1 is a, bit 2*gi is b.
   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      logic [1:0] st_reg;
      logic [1:0] st_next;
      logic       a;
      logic       b;
      logic       rise_a;
      logic       rise_b;

      assign a      = filt[2*gi+1];
      assign b      = filt[2*gi];
      assign rise_a = rise[2*gi+1];
      assign rise_b = rise[2*gi];

      // Last-pressed-wins transitions; both keys from idle selects nothing.
      always_comb begin
         st_next = st_reg;
         if (gameover) begin
            st_next = ST_IDLE;
         end else begin
            case (st_reg)
               ST_IDLE: begin
                  if (a && !b)      st_next = ST_A;
                  else if (b && !a) st_next = ST_B;
                  else              st_next = ST_IDLE;
               end
               ST_A: begin
                  if (!a && !b)         st_next = ST_IDLE;
                  else if (!a && b)     st_next = ST_B;
                  else if (a && rise_b) st_next = ST_B;
                  else                  st_next = ST_A;
               end
               ST_B: begin
                  if (!a && !b)         st_next = ST_IDLE;
                  else if (a && !b)     st_next = ST_A;
                  else if (b && rise_a) st_next = ST_A;
                  else                  st_next = ST_B;
               end
               default: st_next = ST_IDLE;
            endcase
         end
      end

      // Axis state register.
      always_ff @(posedge clk22) begin
         if (rst) st_reg <= ST_IDLE;
         else     st_reg <= st_next;
      end

      assign btn_next[2*gi+1:2*gi] = st_next;
   end

   // Registered direction code and saturating hold counter, updated together
   // so held can compare the upcoming code against the one on the output.
   always_ff @(posedge clk22) begin
      if (rst) begin
         btn_reg  <= 4'b0000;
         held_reg <= 8'd0;
      end else begin
         btn_reg <= btn_next;
         if (btn_next == 4'b0000 || btn_next != btn_reg)
            held_reg <= 8'd0;
         else if (held_reg != 8'hFF)
            held_reg <= held_reg + 8'd1;
      end
   end

   assign btnstate = btn_reg;
   assign held     = held_reg;

endmodule

// File: tb/tb_key_dir_arbiter.sv
// Scoreboard bench for key_dir_arbiter: a driver applies directed and random
// key/gameover/reset patterns and queues the reference model's prediction for
// each edge; an independent monitor pops and compares after every edge.
module tb_key_dir_arbiter;

   localparam int D = 2;

   logic       clk22 = 1'b0;
   logic       rst = 1'b1;
   logic       gameover = 1'b0;
   logic [3:0] keys = 4'b0000;
   logic [3:0] btnstate;
   logic [7:0] held;

   key_dir_arbiter #(.DEBOUNCE(D)) dut (
      .clk22    (clk22),
      .rst      (rst),
      .gameover (gameover),
      .keys     (keys),
      .btnstate (btnstate),
      .held     (held)
   );

   always #5 clk22 = ~clk22;

   typedef struct {
      logic [3:0] btn;
      logic [7:0] held;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: raw sample history per key, filtered levels
   // before the current edge and one edge earlier, per-axis winner
   // (0 none, 1 key a, 2 key b), and the predicted outputs.
   bit   m_hist[4][$];
   bit   m_f[4];
   bit   m_fp[4];
   int   m_dir[2];
   logic [3:0] m_btn;
   int   m_held;

   function automatic logic [1:0] code_of(input int d);
      if (d == 1) return 2'b10;
      if (d == 2) return 2'b01;
      return 2'b00;
   endfunction

   task automatic step(input logic [3:0] k, input logic go, input logic r);
      exp_t e;
      logic [3:0] nb;
      bit nf[4];
      @(negedge clk22);
      keys = k;
      gameover = go;
      rst = r;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            m_hist[i].delete();
            m_f[i] = 0;
            m_fp[i] = 0;
         end
         m_dir[0] = 0;
         m_dir[1] = 0;
         m_btn = 4'b0000;
         m_held = 0;
      end else begin
         // Winner per axis from filtered levels as seen at this edge.
         for (int ax = 0; ax < 2; ax++) begin
            bit a, b, ra, rb;
            a  = m_f[2*ax+1];
            b  = m_f[2*ax];
            ra = a && !m_fp[2*ax+1];
            rb = b && !m_fp[2*ax];
            if (go)                      m_dir[ax] = 0;
            else if (a && !b)            m_dir[ax] = 1;
            else if (b && !a)            m_dir[ax] = 2;
            else if (!a && !b)           m_dir[ax] = 0;
            else if (m_dir[ax] == 1 && rb) m_dir[ax] = 2;
            else if (m_dir[ax] == 2 && ra) m_dir[ax] = 1;
         end
         nb = {code_of(m_dir[1]), code_of(m_dir[0])};
         if (nb == 4'b0000 || nb != m_btn) m_held = 0;
         else if (m_held < 255)            m_held = m_held + 1;
         m_btn = nb;
         // Filtered level follows raw once the last D samples all disagree.
         for (int i = 0; i < 4; i++) begin
            bit all_diff;
            m_hist[i].push_back(k[i]);
            if (m_hist[i].size() > 16) void'(m_hist[i].pop_front());
            all_diff = (m_hist[i].size() >= D);
            if (all_diff)
               for (int j = 0; j < D; j++)
                  if (m_hist[i][m_hist[i].size()-1-j] == m_f[i]) all_diff = 0;
            nf[i] = all_diff ? k[i] : m_f[i];
         end
         for (int i = 0; i < 4; i++) begin
            m_fp[i] = m_f[i];
            m_f[i]  = nf[i];
         end
      end
      e.btn  = m_btn;
      e.held = 8'(m_held);
      sb_q.push_back(e);
   endtask

   task automatic hold(input logic [3:0] k, input logic go, input int n);
      for (int i = 0; i < n; i++) step(k, go, 1'b0);
   endtask

   // Monitor: after each edge compare the outputs with the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk22);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (btnstate !== e.btn || held !== e.held) begin
               miscompares++;
               $display("FAIL edge %0d outputs: btnstate=%b held=%0d, expected btnstate=%b held=%0d",
                        vectors, btnstate, held, e.btn, e.held);
            end
         end
      end
   end

   // Driver: directed scenarios first, then randomized traffic.
   initial begin
      logic [3:0] rk;
      logic       rgo;
      int         wait_cnt;
      // Reset with up held, then release: up after 3 edges, held saturates.
      step(4'b1000, 1'b0, 1'b1);
      step(4'b1000, 1'b0, 1'b1);
      hold(4'b1000, 1'b0, 270);
      hold(4'b0000, 1'b0, 6);
      // Single-edge glitch on right.
      hold(4'b0001, 1'b0, 1);
      hold(4'b0000, 1'b0, 6);
      // Last-wins on the horizontal axis.
      hold(4'b0010, 1'b0, 6);
      hold(4'b0011, 1'b0, 6);
      hold(4'b0010, 1'b0, 6);
      hold(4'b0000, 1'b0, 6);
      // Simultaneous up+down, then release down.
      hold(4'b1100, 1'b0, 6);
      hold(4'b1000, 1'b0, 6);
      hold(4'b0000, 1'b0, 6);
      // Diagonal up+right.
      hold(4'b1001, 1'b0, 6);
      hold(4'b0000, 1'b0, 6);
      // Gameover with right held.
      hold(4'b0001, 1'b0, 6);
      hold(4'b0001, 1'b1, 3);
      hold(4'b0001, 1'b0, 4);
      // Reset mid-operation with keys held.
      step(4'b0110, 1'b0, 1'b1);
      hold(4'b0110, 1'b0, 8);
      // Random traffic: slow key changes, occasional glitches, gameover, reset.
      rk  = 4'b0000;
      rgo = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 7) == 0) rk[i] = ~rk[i];
         if ($urandom_range(0, 39) == 0) rgo = ~rgo;
         step(rk, rgo, ($urandom_range(0, 299) == 0));
      end
      // Let the monitor drain the scoreboard, bounded.
      wait_cnt = 0;
      while (sb_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk22);
         wait_cnt++;
      end
      #2;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
